muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencing controller for the iterative multiply/divide unit that sits beside the main ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU from the ALU control decode and runs a radix-2 shift-add multiplier and a restoring divider over 32 iterations. It owns the HI/LO registers and generates the pipeline stall whenever an instruction needs HI/LO or the unit while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI/LO width; iteration count equals WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  issue request from EX; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  multiplicand / dividend
src_b  in  WIDTH  multiplier / divisor
mthi  in  1  write HI from wdata
mtlo  in  1  write LO from wdata
wdata  in  WIDTH  MTHI/MTLO data
rd_hi  in  1  MFHI in EX
rd_lo  in  1  MFLO in EX
cancel  in  1  pipeline flush; aborts the current operation
busy  out  1  operation in flight (state != IDLE)
stall  out  1  hold IF/ID/EX
done  out  1  one-cycle pulse in FIX state
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0, stall=0, done=0, hi=0, lo=0; internal counter and shift registers cleared.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE: start=1 and cancel=0 at edge E0: latch op and operands, go to PREP. mthi/mtlo update HI/LO at that edge. start together with mthi/mtlo: the operation starts and the MT write still lands at E0.
- PREP, one cycle: compute absolute values for signed ops and record the result signs. Signs are prod_neg = a[31]^b[31]; quot_neg = a[31]^b[31]; rem_neg = a[31]. Counter is cleared. Next state is CALC. DIV/DIVU with src_b==0 goes directly to FIX instead.
- CALC: one iteration per cycle for exactly WIDTH cycles (E2..E33), then FIX.
  - Multiply: 2*WIDTH accumulator, shift-add.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
- FIX, one cycle: done=1. Apply sign correction (two's-complement negate) to the product, quotient and remainder. HI/LO are written at the FIX edge (E34); the state returns to IDLE.
- Latency: busy is high for 34 cycles. hi/lo are valid in the cycle after done.
- Divide by zero: PREP -> FIX. HI=src_a and LO={WIDTH{1}}, with no sign correction, for both DIV and DIVU. busy is high for 2 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap is raised.
- stall = busy & (start | rd_hi | rd_lo | mthi | mtlo). This is combinational and is also high during FIX. start, mthi and mtlo are ignored while busy.
- cancel in any non-IDLE state: next edge goes to IDLE, busy=0, HI/LO unchanged, no done pulse. cancel in IDLE blocks start but does not block mthi/mtlo.
- Every operation overwrites both HI and LO. The multiply result is HI=upper WIDTH bits and LO=lower WIDTH bits.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: for MULT/MULTU, each CALC cycle checks the remaining (unconsumed) multiplier bits. If they are zero, the state moves to FIX on that edge with the accumulator shifted to its final alignment. Divide timing is unchanged; stall and done follow the shortened busy.
- Undefined: multiply always takes WIDTH CALC cycles. Results are bit-identical in both builds.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> done once after 34 busy cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
3. DIVU a=5, b=0 -> busy for 2 cycles, done in the 2nd; HI=5, LO=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. rd_lo held high from the cycle after start -> stall=1 every cycle including FIX, stall=0 in the first IDLE cycle, and lo holds the new result in that cycle. start re-asserted mid-operation is ignored.
5. HI/LO preloaded via mthi=0x11, mtlo=0x22 in IDLE. MULTU 0xFFFFFFFF*2 started, cancel asserted on the 10th CALC cycle -> busy=0 next cycle, no done; HI=0x11, LO=0x22.
6. Asynchronous rst asserted mid-CALC -> busy, stall, done, hi and lo all 0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 3*1 -> done after at most 4 busy cycles; HI=0, LO=3.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the EX-stage stall
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply finishes once remaining multiplier bits are zero)
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, op           issue request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata   direct HI/LO writes (honoured only in IDLE)
//   rd_hi, rd_lo        MFHI/MFLO present in EX
//   cancel              pipeline flush, aborts an operation in flight
//   busy, stall, done   status: in flight, pipeline hold, one-cycle completion pulse
//   hi, lo              HI/LO registers
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_hi,
   input  logic             rd_lo,
   input  logic             cancel,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;
   state_t               r_state, w_next;
   logic [1:0]           r_op;
   logic [WIDTH-1:0]     r_a, r_b, r_m, r_hi, r_lo;
   logic [2*WIDTH-1:0]   r_acc, w_step, w_calc, w_prod;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg_q, r_neg_r, r_dbz;
   logic                 w_div, w_sgn, w_last, w_zero, w_done;
   logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_q, w_r;
   logic [WIDTH:0]       w_sum, w_diff;
   assign w_div   = r_op[1];
   assign w_sgn   = ~r_op[0];
   assign w_abs_a = (w_sgn & r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_abs_b = (w_sgn & r_b[WIDTH-1]) ? -r_b : r_b;
   // multiply: multiplier sits in the low half and is consumed LSB first while the
   // partial product (with its carry bit) shifts down from the high half
   assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
   // divide: the shifted partial remainder needs one extra bit; a set MSB in the
   // difference means the divisor did not fit and the remainder is restored
   assign w_diff  = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
   assign w_step  = w_div ? (w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                           : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                          : (r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]});
`ifdef MULDIV_EARLY_OUT_EN
   logic [CW:0]      w_used;
   logic [WIDTH-1:0] w_rest;
   // after this step w_used multiplier bits are consumed; the rest live in the low bits
   assign w_used = {1'b0, r_cnt} + (CW+1)'(1);
   assign w_rest = w_step[WIDTH-1:0] << w_used;
   assign w_zero = ~w_div & (w_rest == '0);
   // no further adds can occur, so the outstanding shifts are applied in one go
   assign w_calc = w_zero ? (w_step >> (CW'(WIDTH-1) - r_cnt)) : w_step;
`else
   assign w_zero = 1'b0;
   assign w_calc = w_step;
`endif
   assign w_last = (r_cnt == CW'(WIDTH-1)) | w_zero;
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_q    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: w_next = (start && !cancel) ? S_PREP : S_IDLE;
         S_PREP: w_next = cancel ? S_IDLE : (w_div && r_b == '0) ? S_FIX : S_CALC;
         S_CALC: w_next = cancel ? S_IDLE : w_last ? S_FIX : S_CALC;
         S_FIX: begin
            w_next = S_IDLE;
            w_done = ~cancel;
         end
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_m     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dbz   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !cancel) begin
                  r_op <= op;
                  r_a  <= src_a;
                  r_b  <= src_b;
               end
               if (mthi) r_hi <= wdata;
               if (mtlo) r_lo <= wdata;
            end
            S_PREP: begin
               r_cnt   <= '0;
               r_neg_q <= w_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
               r_neg_r <= w_sgn & r_a[WIDTH-1];
               r_dbz   <= w_div & (r_b == '0);
               r_m     <= w_div ? w_abs_b : w_abs_a;
               r_acc   <= {{WIDTH{1'b0}}, w_div ? w_abs_a : w_abs_b};
            end
            S_CALC: begin
               r_acc <= w_calc;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               if (!cancel) begin
                  r_hi <= r_dbz ? r_a : w_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= r_dbz ? {WIDTH{1'b1}} : w_div ? w_q : w_prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end
   assign busy  = r_state != S_IDLE;
   assign stall = busy & (start | rd_hi | rd_lo | mthi | mtlo);
   assign done  = w_done;
   assign hi    = r_hi;
   assign lo    = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;
   localparam int W = 32;
   typedef struct {
      logic [1:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;
   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
   logic         rd_hi = 1'b0, rd_lo = 1'b0, cancel = 1'b0;
   logic [1:0]   op = '0;
   logic [W-1:0] src_a = '0, src_b = '0, wdata = '0;
   logic         busy, stall, done;
   logic [W-1:0] hi, lo;
   int           n_chk = 0, n_err = 0;
   logic [63:0]  sb_q[$];
   vec_t         tv[11];
   always #5 clk = ~clk;
   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hi(rd_hi), .rd_lo(rd_lo),
      .cancel(cancel), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'd0: return 64'(sa * sb);
         2'd1: return {32'b0, a} * {32'b0, b};
         2'd2: return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
         default: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      endcase
   endfunction
   function automatic int exp_busy(input logic [1:0] o, input logic [W-1:0] b);
      if (o[1]) return (b == 0) ? 2 : 34;
`ifdef MULDIV_EARLY_OUT_EN
      begin
         logic [W-1:0] m;
         int           k;
         m = (!o[0] && b[W-1]) ? -b : b;
         k = 1;
         for (int i = 1; i < W; i++) if (m[i]) k = i + 1;
         return 2 + k;
      end
`else
      return 34;
`endif
   endfunction
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit rdl);
      int          n, d;
      logic [63:0] e;
      sb_q.push_back(model(o, a, b));
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; rd_lo = rdl;
      #1;
      n = 0; d = 0;
      while (busy && n < 100) begin
         n++;
         if (done) d++;
         if (rdl) check("stall_busy", stall, 1);
         @(negedge clk);
         start = rdl && n == 4;
         #1;
      end
      check("busy_cycles", n, exp_busy(o, b));
      check("done_count", d, 1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check("hi", hi, e[63:32]);
      check("lo", lo, e[31:0]);
      if (rdl) check("stall_idle", stall, 0);
      rd_lo = 1'b0;
   endtask
   initial begin
      int n, d;
      tv = '{'{2'd0, 32'hFFFFFFFD, 32'd7},
             '{2'd2, 32'hFFFFFFF9, 32'd2},
             '{2'd3, 32'd100, 32'd7},
             '{2'd3, 32'd5, 32'd0},
             '{2'd2, 32'h80000000, 32'hFFFFFFFF},
             '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF},
             '{2'd0, 32'h80000000, 32'h80000000},
             '{2'd2, 32'd7, 32'hFFFFFFFE},
             '{2'd2, 32'hFFFFFFF0, 32'd0},
             '{2'd0, 32'h12345678, 32'hFEDCBA98},
             '{2'd1, 32'd3, 32'd1}};
      #12;
      check("rst_busy", busy, 0);
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      @(negedge clk);
      rst = 1'b0;
      foreach (tv[i]) do_op(tv[i].o, tv[i].a, tv[i].b, 1'b0);
      do_op(2'd3, 32'd1000, 32'd13, 1'b1);
      // HI/LO preload while cancel blocks a start, then cancelled multiply
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; mthi = 1'b1; wdata = 32'h11;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0; mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
      #1;
      check("cancel_blocks_start", busy, 0);
      check("mthi", hi, 32'h11);
      @(negedge clk);
      mtlo = 1'b0;
      #1;
      check("mtlo", lo, 32'h22);
      @(negedge clk);
      start = 1'b1; op = 2'd1; src_a = 32'd2; src_b = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
      #1;
      n = 1; d = 0;
      while (n < 11) begin
         if (done) d++;
         @(negedge clk);
         #1;
         n++;
      end
      check("busy_calc10", busy, 1);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      #1;
      if (done) d++;
      check("cancel_busy", busy, 0);
      @(negedge clk);
      #1;
      if (done) d++;
      check("cancel_done", d, 0);
      check("cancel_hi", hi, 32'h11);
      check("cancel_lo", lo, 32'h22);
      // asynchronous reset in the middle of a multiply
      @(negedge clk);
      start = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'h40000000;
      @(negedge clk);
      start = 1'b0; rd_lo = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("stall_pre_rst", stall, 1);
      #1 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_stall", stall, 0);
      check("arst_done", done, 0);
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      @(negedge clk);
      rst = 1'b0; rd_lo = 1'b0;
      #1;
      check("post_rst_busy", busy, 0);
      do_op(2'd1, 32'd3, 32'd1, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
